// File: rtl/tri_scan_engine.sv
// Triangle setup + raster-order scan: latches one triangle, clips its bbox to a tile,
// and streams covered pixels with incremental edge values over a valid/ready port.
module tri_scan_engine #(
    parameter int COORD_W = 12,
    parameter int TILE_X0 = 0,
    parameter int TILE_Y0 = 0,
    parameter int TILE_W  = 320,
    parameter int TILE_H  = 240
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_draw,
    input  logic [1:0]             i_cull_mode,
    input  logic [COORD_W-1:0]     i_v1_x,
    input  logic [COORD_W-1:0]     i_v1_y,
    input  logic [COORD_W-1:0]     i_v2_x,
    input  logic [COORD_W-1:0]     i_v2_y,
    input  logic [COORD_W-1:0]     i_v3_x,
    input  logic [COORD_W-1:0]     i_v3_y,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [COORD_W-1:0]     o_x,
    output logic [COORD_W-1:0]     o_y,
    output logic [2*COORD_W+1:0]   o_e1,
    output logic [2*COORD_W+1:0]   o_e2,
    output logic [2*COORD_W+1:0]   o_e3,
    output logic [2*COORD_W+1:0]   o_area,
    output logic [31:0]            o_pix_count
);
    localparam int EDGE_W = 2*COORD_W+2;
    localparam logic signed [COORD_W-1:0] TX0 = COORD_W'(TILE_X0);
    localparam logic signed [COORD_W-1:0] TY0 = COORD_W'(TILE_Y0);
    localparam logic signed [COORD_W-1:0] TX1 = COORD_W'(TILE_X0 + TILE_W - 1);
    localparam logic signed [COORD_W-1:0] TY1 = COORD_W'(TILE_Y0 + TILE_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CLIP, S_SCAN, S_DRAIN} state_t;

    function automatic logic signed [EDGE_W-1:0] ext(input logic signed [COORD_W-1:0] a);
        return EDGE_W'(a);
    endfunction
    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a, b, c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction
    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a, b, c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    state_t                     state_q, state_d;
    logic [1:0]                 cull_q;
    logic signed [COORD_W-1:0]  vx_q [3];
    logic signed [COORD_W-1:0]  vy_q [3];
    // Edge i runs from vertex (i+1)%3 to (i+2)%3; dx/dy are b-a of that edge.
    logic signed [EDGE_W-1:0]   dx_q [3];
    logic signed [EDGE_W-1:0]   dy_q [3];
    logic signed [EDGE_W-1:0]   area_q;
    logic signed [COORD_W-1:0]  bx0_q, bx1_q, by0_q, by1_q;
    logic signed [COORD_W-1:0]  x_q, y_q;
    logic signed [EDGE_W-1:0]   e_q [3];
    logic signed [EDGE_W-1:0]   erow_q [3];
    logic                       vld_q, done_q;
    logic [COORD_W-1:0]         ox_q, oy_q;
    logic [EDGE_W-1:0]          oe_q [3];
    logic [EDGE_W-1:0]          oarea_q;
    logic [31:0]                cnt_q;

    logic signed [COORD_W-1:0]  cx0, cx1, cy0, cy1;
    logic signed [EDGE_W-1:0]   ei_c [3];
    logic                       clip_skip, scan_adv, last_px, cov;

    always_comb begin
        cx0 = (bx0_q < TX0) ? TX0 : bx0_q;
        cx1 = (bx1_q > TX1) ? TX1 : bx1_q;
        cy0 = (by0_q < TY0) ? TY0 : by0_q;
        cy1 = (by1_q > TY1) ? TY1 : by1_q;
        for (int i = 0; i < 3; i++) begin
            ei_c[i] = (ext(cx0) - ext(vx_q[(i+1)%3])) * dy_q[i]
                    - (ext(cy0) - ext(vy_q[(i+1)%3])) * dx_q[i];
        end
        clip_skip = (area_q == '0)
                 || (cull_q == 2'd1 && area_q < 0)
                 || (cull_q == 2'd2 && area_q > 0)
                 || (cx0 > cx1) || (cy0 > cy1);
        scan_adv = !vld_q || i_ready;
        last_px  = (x_q == bx1_q) && (y_q == by1_q);
        // Area is never zero during scan, so its sign selects the inclusive test.
        if (area_q[EDGE_W-1])
            cov = (e_q[0] <= 0) && (e_q[1] <= 0) && (e_q[2] <= 0);
        else
            cov = (e_q[0] >= 0) && (e_q[1] >= 0) && (e_q[2] >= 0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_draw) state_d = S_SETUP;
            S_SETUP: state_d = S_CLIP;
            S_CLIP:  state_d = clip_skip ? S_DRAIN : S_SCAN;
            S_SCAN:  if (scan_adv && last_px) state_d = S_DRAIN;
            S_DRAIN: if (!vld_q || i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cull_q  <= '0;
            area_q  <= '0;
            bx0_q   <= '0; bx1_q <= '0; by0_q <= '0; by1_q <= '0;
            x_q     <= '0; y_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            ox_q    <= '0; oy_q  <= '0;
            oarea_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0; vy_q[i] <= '0;
                dx_q[i] <= '0; dy_q[i] <= '0;
                e_q[i]  <= '0; erow_q[i] <= '0;
                oe_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (vld_q && i_ready) begin
                vld_q <= 1'b0;
                cnt_q <= cnt_q + 32'd1;
            end
            case (state_q)
                S_IDLE: if (i_draw) begin
                    cull_q  <= i_cull_mode;
                    vx_q[0] <= i_v1_x; vy_q[0] <= i_v1_y;
                    vx_q[1] <= i_v2_x; vy_q[1] <= i_v2_y;
                    vx_q[2] <= i_v3_x; vy_q[2] <= i_v3_y;
                end
                S_SETUP: begin
                    for (int i = 0; i < 3; i++) begin
                        dx_q[i] <= ext(vx_q[(i+2)%3]) - ext(vx_q[(i+1)%3]);
                        dy_q[i] <= ext(vy_q[(i+2)%3]) - ext(vy_q[(i+1)%3]);
                    end
                    area_q <= (ext(vx_q[2]) - ext(vx_q[0])) * (ext(vy_q[1]) - ext(vy_q[0]))
                            - (ext(vy_q[2]) - ext(vy_q[0])) * (ext(vx_q[1]) - ext(vx_q[0]));
                    bx0_q <= min3(vx_q[0], vx_q[1], vx_q[2]);
                    bx1_q <= max3(vx_q[0], vx_q[1], vx_q[2]);
                    by0_q <= min3(vy_q[0], vy_q[1], vy_q[2]);
                    by1_q <= max3(vy_q[0], vy_q[1], vy_q[2]);
                end
                S_CLIP: begin
                    bx0_q <= cx0; bx1_q <= cx1; by0_q <= cy0; by1_q <= cy1;
                    x_q   <= cx0; y_q   <= cy0;
                    for (int i = 0; i < 3; i++) begin
                        e_q[i]    <= ei_c[i];
                        erow_q[i] <= ei_c[i];
                    end
                end
                S_SCAN: if (scan_adv) begin
                    if (cov) begin
                        vld_q   <= 1'b1;
                        ox_q    <= x_q;
                        oy_q    <= y_q;
                        oarea_q <= area_q;
                        for (int i = 0; i < 3; i++) oe_q[i] <= e_q[i];
                    end
                    if (x_q == bx1_q) begin
                        x_q <= bx0_q;
                        y_q <= y_q + COORD_W'(1);
                        for (int i = 0; i < 3; i++) begin
                            erow_q[i] <= erow_q[i] - dx_q[i];
                            e_q[i]    <= erow_q[i] - dx_q[i];
                        end
                    end else begin
                        x_q <= x_q + COORD_W'(1);
                        for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + dy_q[i];
                    end
                end
                S_DRAIN: if (!vld_q || i_ready) done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_valid     = vld_q;
    assign o_x         = ox_q;
    assign o_y         = oy_q;
    assign o_e1        = oe_q[0];
    assign o_e2        = oe_q[1];
    assign o_e3        = oe_q[2];
    assign o_area      = oarea_q;
    assign o_pix_count = cnt_q;
endmodule

// File: tb/tb_tri_scan_engine.sv
// Directed bench for tri_scan_engine: default-tile instance plus a 16x16-tile instance.
module tb_tri_scan_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, draw, draw16, rdy;
    logic [1:0]         cull;
    logic [11:0]        v1x, v1y, v2x, v2y, v3x, v3y;
    logic               busy, done, vld;
    logic signed [11:0] ox, oy;
    logic signed [25:0] oe1, oe2, oe3, oarea;
    logic [31:0]        cnt;
    logic               busy16, done16, vld16;
    logic signed [11:0] ox16, oy16;
    logic signed [25:0] oe1_16, oe2_16, oe3_16, oarea16;
    logic [31:0]        cnt16;

    tri_scan_engine dut (
        .i_clk(clk), .i_reset(rst), .i_draw(draw), .i_cull_mode(cull),
        .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
        .o_busy(busy), .o_done(done), .o_valid(vld), .i_ready(rdy),
        .o_x(ox), .o_y(oy), .o_e1(oe1), .o_e2(oe2), .o_e3(oe3), .o_area(oarea),
        .o_pix_count(cnt));

    tri_scan_engine #(.TILE_W(16), .TILE_H(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_draw(draw16), .i_cull_mode(cull),
        .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
        .o_busy(busy16), .o_done(done16), .o_valid(vld16), .i_ready(rdy),
        .o_x(ox16), .o_y(oy16), .o_e1(oe1_16), .o_e2(oe2_16), .o_e3(oe3_16), .o_area(oarea16),
        .o_pix_count(cnt16));

    typedef struct { int x; int y; int e1; int e2; int e3; int a; } pix_t;
    pix_t pq[$];
    pix_t ex1[$];
    int   q16x[$];
    int   q16y[$];
    int   done_cnt, done16_cnt, stall_err;
    int   tests, fails;
    bit   stall_prev;
    pix_t held;

    always @(negedge clk) begin
        pix_t p;
        if (stall_prev) begin
            if (vld !== 1'b1 || ox != held.x || oy != held.y || oe1 != held.e1 ||
                oe2 != held.e2 || oe3 != held.e3 || oarea != held.a)
                stall_err++;
        end
        p.x = ox; p.y = oy; p.e1 = oe1; p.e2 = oe2; p.e3 = oe3; p.a = oarea;
        stall_prev = vld && !rdy;
        held = p;
        if (vld && rdy) pq.push_back(p);
        if (done) done_cnt++;
        if (vld16 && rdy) begin q16x.push_back(int'(ox16)); q16y.push_back(int'(oy16)); end
        if (done16) done16_cnt++;
    end

    // Hand-derived for v=(0,0),(4,0),(0,4): e1=4x+4y-16, e2=-4x, e3=-4y, area=-16.
    function automatic int first_bad();
        if (pq.size() != ex1.size()) return -2;
        foreach (pq[k])
            if (pq[k].x != ex1[k].x || pq[k].y != ex1[k].y || pq[k].e1 != ex1[k].e1 ||
                pq[k].e2 != ex1[k].e2 || pq[k].e3 != ex1[k].e3 || pq[k].a != ex1[k].a)
                return k;
        return -1;
    endfunction

    task automatic start(input int x1, y1, x2, y2, x3, y3, input logic [1:0] cm, input bit big);
        pq.delete(); q16x.delete(); q16y.delete();
        done_cnt = 0; done16_cnt = 0;
        v1x = 12'(x1); v1y = 12'(y1); v2x = 12'(x2); v2y = 12'(y2); v3x = 12'(x3); v3y = 12'(y3);
        cull = cm;
        if (big) draw16 = 1'b1; else draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0; draw16 = 1'b0;
    endtask

    task automatic wait_done(input bit big, input bit rnd, input bit mid, input int budget,
                             output int cyc);
        bit to;
        cyc = 0; to = 1'b1;
        while (cyc < budget) begin
            rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            draw = (mid && cyc == 8);
            if (mid && cyc == 8) cull = 2'd1;
            @(posedge clk); #1;
            cyc++;
            if (big ? done16 : done) begin to = 1'b0; break; end
        end
        rdy = 1'b1; draw = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (to) begin fails++; $display("FAIL done_timeout: no o_done within %0d cycles", budget); end
    endtask

    task automatic test_reset();
        if (vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, want 0 0 0", vld, busy, done);
        end
        tests++;
        if (cnt !== 32'd0 || ox !== 12'sd0 || oy !== 12'sd0 || oarea !== 26'sd0 || oe1 !== 26'sd0) begin
            fails++; $display("FAIL reset_data: cnt=%0d x=%0d y=%0d area=%0d e1=%0d, want all 0",
                              cnt, ox, oy, oarea, oe1);
        end
        tests++;
    endtask

    task automatic test_basic();
        int cyc, bad;
        start(0, 0, 4, 0, 0, 4, 2'd0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 200, cyc);
        bad = first_bad();
        tests++;
        if (bad != -1) begin fails++; $display("FAIL basic_seq: first bad index %0d (got %0d pixels), want -1 / 15", bad, pq.size()); end
        tests++;
        if (pq.size() == 0 || pq[0].x != 0 || pq[0].y != 0 || pq[0].e3 != 0) begin
            fails++; $display("FAIL basic_first: pixel count %0d, want first (0,0) e3=0", pq.size());
        end
        tests++;
        if (pq.size() == 0 || pq[$].x != 0 || pq[$].y != 4) begin
            fails++; $display("FAIL basic_last: pixel count %0d, want last pixel (0,4)", pq.size());
        end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL basic_done: %0d pulses, want 1", done_cnt); end
        tests++;
        if (cnt !== 32'd15) begin fails++; $display("FAIL basic_count: %0d, want 15", cnt); end
    endtask

    task automatic test_cull();
        int cyc, bad;
        start(0, 0, 4, 0, 0, 4, 2'd1, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 50, cyc);
        tests++;
        if (pq.size() != 0 || done_cnt != 1) begin
            fails++; $display("FAIL cull1: %0d pixels %0d dones, want 0 and 1", pq.size(), done_cnt);
        end
        tests++;
        if (cyc > 5) begin fails++; $display("FAIL cull1_latency: done after %0d cycles, want <= 5", cyc); end
        start(0, 0, 4, 0, 0, 4, 2'd2, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 200, cyc);
        bad = first_bad();
        tests++;
        if (bad != -1 || done_cnt != 1) begin
            fails++; $display("FAIL cull2_seq: first bad %0d (got %0d pixels, %0d dones), want -1 / 15 / 1", bad, pq.size(), done_cnt);
        end
        tests++;
        if (cnt !== 32'd30) begin fails++; $display("FAIL cull_count: %0d, want 30", cnt); end
    endtask

    task automatic test_degenerate();
        int cyc;
        start(0, 0, 2, 2, 4, 4, 2'd0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 50, cyc);
        tests++;
        if (pq.size() != 0 || done_cnt != 1) begin
            fails++; $display("FAIL collinear: %0d pixels %0d dones, want 0 and 1", pq.size(), done_cnt);
        end
        start(-5, 0, -8, 4, -3, 6, 2'd0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 50, cyc);
        tests++;
        if (pq.size() != 0 || done_cnt != 1) begin
            fails++; $display("FAIL outside_tile: %0d pixels %0d dones, want 0 and 1", pq.size(), done_cnt);
        end
        tests++;
        if (cnt !== 32'd30) begin fails++; $display("FAIL degen_count: %0d, want 30", cnt); end
    endtask

    task automatic test_clip();
        int cyc, errs;
        start(-10, -10, 30, -10, -10, 30, 2'd0, 1'b1);
        wait_done(1'b1, 1'b0, 1'b0, 600, cyc);
        tests++;
        if (q16x.size() != 201 || done16_cnt != 1) begin
            fails++; $display("FAIL clip_count: %0d pixels %0d dones, want 201 and 1", q16x.size(), done16_cnt);
        end
        errs = 0;
        foreach (q16x[k]) begin
            if (q16x[k] < 0 || q16x[k] > 15 || q16y[k] < 0 || q16y[k] > 15 || q16x[k] + q16y[k] > 20) errs++;
            if (k > 0 && q16y[k]*16 + q16x[k] <= q16y[k-1]*16 + q16x[k-1]) errs++;
        end
        tests++;
        if (errs != 0) begin fails++; $display("FAIL clip_range: %0d bad pixels, want 0", errs); end
        tests++;
        if (cnt16 !== 32'd201) begin fails++; $display("FAIL clip_pixcount: %0d, want 201", cnt16); end
    endtask

    task automatic test_backpressure();
        int cyc, bad;
        stall_err = 0;
        start(0, 0, 4, 0, 0, 4, 2'd0, 1'b0);
        wait_done(1'b0, 1'b1, 1'b1, 400, cyc);
        bad = first_bad();
        tests++;
        if (bad != -1) begin fails++; $display("FAIL bp_seq: first bad index %0d (got %0d pixels), want -1 / 15", bad, pq.size()); end
        tests++;
        if (stall_err != 0) begin fails++; $display("FAIL bp_stable: %0d payload changes during stall, want 0", stall_err); end
        tests++;
        if (done_cnt != 1 || cnt !== 32'd45) begin
            fails++; $display("FAIL bp_done: %0d dones count %0d, want 1 and 45", done_cnt, cnt);
        end
    endtask

    task automatic test_reset_midscan();
        int cyc, n, bad;
        start(0, 0, 4, 0, 0, 4, 2'd0, 1'b0);
        rdy = 1'b1;
        cyc = 0;
        while (pq.size() < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1; rdy = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (vld !== 1'b0 || busy !== 1'b0 || cnt !== 32'd0) begin
            fails++; $display("FAIL midreset: valid=%b busy=%b cnt=%0d (after %0d pixels), want 0 0 0 / 5", vld, busy, cnt, pq.size());
        end
        rst = 1'b0; rdy = 1'b1;
        n = pq.size();
        done_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 0 || pq.size() != n) begin
            fails++; $display("FAIL midreset_quiet: %0d dones %0d new pixels, want 0 and 0", done_cnt, pq.size() - n);
        end
        start(0, 0, 4, 0, 0, 4, 2'd0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0, 200, cyc);
        bad = first_bad();
        tests++;
        if (bad != -1 || done_cnt != 1 || cnt !== 32'd15) begin
            fails++; $display("FAIL after_reset: bad %0d dones %0d cnt %0d, want -1 1 15", bad, done_cnt, cnt);
        end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0; done16_cnt = 0; stall_err = 0; stall_prev = 1'b0;
        rst = 1'b1; draw = 1'b0; draw16 = 1'b0; rdy = 1'b1; cull = 2'd0;
        v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) ex1.push_back('{x, y, 4*x + 4*y - 16, -4*x, -4*y, -16});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_cull();
        test_degenerate();
        test_clip();
        test_backpressure();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
